// File: rtl/fetch_stage_pkg.sv
// Shared type packages for the pipeline.
//   BasicTypes      : TRUE/FALSE single-bit constants.
//   ControllerTypes : StageCtrl (per-stage stall/flush controls from the
//                     stage controller), FetchState (fetch FSM encoding) and
//                     INSN_BYTES (PC increment per instruction).

package BasicTypes;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

package ControllerTypes;

  // Controls driven to one pipeline stage by the stage controller.
  typedef struct packed {
    logic stall;   // hold the stage's state and output register
    logic flush;   // squash the stage's output register
  } StageCtrl;

  // Fetch FSM:
  //   ISSUE : request for pc may be presented to instruction memory
  //   WAIT  : one request outstanding, waiting for the response
  //   HELD  : response captured in the hold buffer while decode is stalled
  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HELD  = 2'd2
  } FetchState;

  localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: fetch stage of the in-order pipeline.
// Holds the PC, issues at most one instruction-memory request at a time and
// writes the returned instruction into the IF/ID pipeline register.
//
// Handshake: a request transfers on a cycle where imemReqValid && imemReqReady
// are both high; imemReqValid may only drop after such a transfer, except when
// a redirect or flush arrives (the request is withdrawn and re-evaluated next
// cycle). Responses need no ready: imemRespValid is a one-cycle strobe that
// this stage always consumes while in WAIT.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ctrl            stall/flush controls for this stage
//   redirectValid   load redirectPc into pc (branch taken / mispredict)
//   redirectPc      redirect target, word aligned
//   imemReqValid    request valid
//   imemReqAddr     request address (always equals pc)
//   imemReqReady    memory accepts the request this cycle
//   imemRespValid   response valid
//   imemRespData    instruction word
//   ifIdValid       IF/ID holds a live instruction
//   ifIdPc          PC of that instruction
//   ifIdInsn        that instruction
//   fetchBusy       a request is outstanding (state WAIT)

module fetch_stage
  import BasicTypes::*;
  import ControllerTypes::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  StageCtrl    ctrl,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        ifIdValid,
  output logic [31:0] ifIdPc,
  output logic [31:0] ifIdInsn,
  output logic        fetchBusy
);

  FetchState   state, stateNext;
  logic [31:0] pc, pcNext;
  logic        discard, discardNext;
  logic [31:0] holdInsn;
  logic        holdLoad;
  logic        deliver;
  logic [31:0] deliverInsn;
  logic        reqFire;

  assign imemReqValid = (state == ISSUE) && !redirectValid && !ctrl.flush;
  assign imemReqAddr  = pc;
  assign fetchBusy    = (state == WAIT);
  assign reqFire      = imemReqValid && imemReqReady;

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    discardNext = discard;
    holdLoad    = FALSE;
    deliver     = FALSE;
    deliverInsn = holdInsn;
    case (state)
      ISSUE: begin
        if (redirectValid) begin
          pcNext = redirectPc;
        end else if (reqFire) begin
          stateNext   = WAIT;
          discardNext = FALSE;
        end
      end
      WAIT: begin
        // A redirect while waiting poisons the in-flight response, however
        // late it arrives; discard stays set until the next request is accepted.
        if (redirectValid) begin
          pcNext      = redirectPc;
          discardNext = TRUE;
        end
        if (imemRespValid) begin
          stateNext = ISSUE;
          if (discard || redirectValid) begin
            // stale response, dropped
          end else if (ctrl.flush) begin
            // dropped; pc is left alone so the same address is refetched
          end else if (ctrl.stall) begin
            holdLoad  = TRUE;
            stateNext = HELD;
          end else begin
            deliver     = TRUE;
            deliverInsn = imemRespData;
            pcNext      = pc + 32'(INSN_BYTES);
          end
        end
      end
      HELD: begin
        if (redirectValid) begin
          pcNext    = redirectPc;
          stateNext = ISSUE;
        end else if (ctrl.flush) begin
          stateNext = ISSUE;
        end else if (!ctrl.stall) begin
          deliver   = TRUE;
          pcNext    = pc + 32'(INSN_BYTES);
          stateNext = ISSUE;
        end
      end
      default: begin
        stateNext = ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      discard   <= FALSE;
      holdInsn  <= 32'h0;
      ifIdValid <= FALSE;
      ifIdPc    <= 32'h0;
      ifIdInsn  <= 32'h0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      discard <= discardNext;
      if (holdLoad) begin
        holdInsn <= imemRespData;
      end
      // Flush wins over stall; deliver is never set while either is high.
      if (ctrl.flush) begin
        ifIdValid <= FALSE;
      end else if (ctrl.stall) begin
        ifIdValid <= ifIdValid;
      end else if (deliver) begin
        ifIdValid <= TRUE;
        ifIdPc    <= pc;
        ifIdInsn  <= deliverInsn;
      end else begin
        ifIdValid <= FALSE;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import ControllerTypes::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (RESET_PC = 0)
  logic        rst;
  StageCtrl    ctrl;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        ifIdValid;
  logic [31:0] ifIdPc;
  logic [31:0] ifIdInsn;
  logic        fetchBusy;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .ifIdValid(ifIdValid), .ifIdPc(ifIdPc), .ifIdInsn(ifIdInsn),
    .fetchBusy(fetchBusy)
  );

  // wrap DUT (RESET_PC = FFFF_FFFC)
  logic        wRst;
  StageCtrl    wCtrl;
  logic        wRedirectValid;
  logic [31:0] wRedirectPc;
  logic        wReqValid;
  logic [31:0] wReqAddr;
  logic        wReqReady;
  logic        wRespValid;
  logic [31:0] wRespData;
  logic        wIfIdValid;
  logic [31:0] wIfIdPc;
  logic [31:0] wIfIdInsn;
  logic        wBusy;

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst(wRst), .ctrl(wCtrl),
    .redirectValid(wRedirectValid), .redirectPc(wRedirectPc),
    .imemReqValid(wReqValid), .imemReqAddr(wReqAddr), .imemReqReady(wReqReady),
    .imemRespValid(wRespValid), .imemRespData(wRespData),
    .ifIdValid(wIfIdValid), .ifIdPc(wIfIdPc), .ifIdInsn(wIfIdInsn),
    .fetchBusy(wBusy)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // scoreboard: expected accepted request addresses and expected IF/ID loads {pc, insn}
  logic [31:0] exp_q[$];
  logic [63:0] exp_ifid_q[$];

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    int          delay;   // response latency for a request accepted this cycle
    logic        eReqV;
    logic [31:0] eAddr;
    logic        eBusy;
    logic        eIfV;
    logic [31:0] eIfPc;   // checked only when eIfV
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  function automatic vec_t v(input logic r, input logic s, input logic f, input logic rd,
                             input logic [31:0] rp, input logic rdy, input int d,
                             input logic qv, input logic [31:0] qa, input logic b,
                             input logic iv, input logic [31:0] ip);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.redir = rd; x.rpc = rp; x.ready = rdy;
    x.delay = d; x.eReqV = qv; x.eAddr = qa; x.eBusy = b; x.eIfV = iv; x.eIfPc = ip;
    return x;
  endfunction

  // memory model state
  logic        memPend;
  int          memCnt;
  logic [31:0] memAddr;

  // ---------------- driver + monitor ----------------
  initial begin : main
    logic        accept;
    logic [31:0] acceptAddr;
    logic        prevHold;
    logic [31:0] tmp;
    logic [63:0] tmp64;

    //          rst s f rd rpc          rdy d  reqV addr       busy ifV ifPc
    vecs[0]  = v(0, 0,0,0, 32'h0,       1, 1,  1, 32'h0,      0,   0, 32'h0);   // free run
    vecs[1]  = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h0,      1,   0, 32'h0);
    vecs[2]  = v(0, 0,0,0, 32'h0,       1, 1,  1, 32'h4,      0,   1, 32'h0);
    vecs[3]  = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h4,      1,   0, 32'h0);
    vecs[4]  = v(0, 1,0,0, 32'h0,       1, 1,  1, 32'h8,      0,   1, 32'h4);   // stall around resp for 8
    vecs[5]  = v(0, 1,0,0, 32'h0,       1, 1,  0, 32'h8,      1,   1, 32'h4);
    vecs[6]  = v(0, 1,0,0, 32'h0,       1, 1,  0, 32'h8,      0,   1, 32'h4);   // HELD
    vecs[7]  = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h8,      0,   1, 32'h4);   // release
    vecs[8]  = v(0, 0,0,0, 32'h0,       1, 2,  1, 32'hC,      0,   1, 32'h8);
    vecs[9]  = v(0, 0,0,1, 32'h100,     1, 1,  0, 32'hC,      1,   0, 32'h0);   // redirect in WAIT
    vecs[10] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h100,    1,   0, 32'h0);   // late resp dropped
    vecs[11] = v(0, 0,0,0, 32'h0,       1, 1,  1, 32'h100,    0,   0, 32'h0);
    vecs[12] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h100,    1,   0, 32'h0);
    vecs[13] = v(0, 0,0,1, 32'h10,      1, 1,  0, 32'h104,    0,   1, 32'h100); // redirect in ISSUE
    vecs[14] = v(0, 0,0,0, 32'h0,       1, 1,  1, 32'h10,     0,   0, 32'h0);
    vecs[15] = v(0, 1,1,0, 32'h0,       1, 1,  0, 32'h10,     1,   0, 32'h0);   // flush+stall on resp
    vecs[16] = v(0, 0,0,0, 32'h0,       1, 1,  1, 32'h10,     0,   0, 32'h0);   // refetch 10
    vecs[17] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h10,     1,   0, 32'h0);
    vecs[18] = v(0, 0,0,0, 32'h0,       0, 1,  1, 32'h14,     0,   1, 32'h10);  // slow memory
    vecs[19] = v(0, 0,0,0, 32'h0,       0, 1,  1, 32'h14,     0,   0, 32'h0);
    vecs[20] = v(0, 0,0,0, 32'h0,       0, 1,  1, 32'h14,     0,   0, 32'h0);
    vecs[21] = v(0, 0,0,0, 32'h0,       0, 1,  1, 32'h14,     0,   0, 32'h0);
    vecs[22] = v(0, 0,0,0, 32'h0,       1, 5,  1, 32'h14,     0,   0, 32'h0);
    vecs[23] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h14,     1,   0, 32'h0);
    vecs[24] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h14,     1,   0, 32'h0);
    vecs[25] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h14,     1,   0, 32'h0);
    vecs[26] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h14,     1,   0, 32'h0);
    vecs[27] = v(0, 0,0,0, 32'h0,       1, 1,  0, 32'h14,     1,   0, 32'h0);
    vecs[28] = v(0, 0,0,0, 32'h0,       1, 1,  1, 32'h18,     0,   1, 32'h14);
    vecs[29] = v(1, 0,0,0, 32'h0,       1, 1,  0, 32'h18,     1,   0, 32'h0);   // reset mid-flight
    vecs[30] = v(0, 0,0,0, 32'h0,       1, 1,  1, 32'h0,      0,   0, 32'h0);

    // expected traffic for the whole run
    exp_q.push_back(32'h0);   exp_q.push_back(32'h4);   exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);   exp_q.push_back(32'h100); exp_q.push_back(32'h10);
    exp_q.push_back(32'h10);  exp_q.push_back(32'h14);  exp_q.push_back(32'h18);
    exp_q.push_back(32'h0);
    exp_ifid_q.push_back({32'h0,   memData(32'h0)});
    exp_ifid_q.push_back({32'h4,   memData(32'h4)});
    exp_ifid_q.push_back({32'h8,   memData(32'h8)});
    exp_ifid_q.push_back({32'h100, memData(32'h100)});
    exp_ifid_q.push_back({32'h10,  memData(32'h10)});
    exp_ifid_q.push_back({32'h14,  memData(32'h14)});

    // reset both DUTs
    rst = 1'b1; ctrl = '0; redirectValid = 1'b0; redirectPc = 32'h0;
    imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = 32'h0;
    wRst = 1'b1; wCtrl = '0; wRedirectValid = 1'b0; wRedirectPc = 32'h0;
    wReqReady = 1'b0; wRespValid = 1'b0; wRespData = 32'h0;
    memPend = 1'b0; memCnt = 0; memAddr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset ifIdValid", 32'(ifIdValid), 32'h0);
    check32("reset ifIdPc",    ifIdPc,         32'h0);
    check32("reset ifIdInsn",  ifIdInsn,       32'h0);
    check32("reset fetchBusy", 32'(fetchBusy), 32'h0);

    prevHold = 1'b1;
    for (int i = 0; i < NV; i++) begin
      rst           = vecs[i].rst;
      ctrl.stall    = vecs[i].stall;
      ctrl.flush    = vecs[i].flush;
      redirectValid = vecs[i].redir;
      redirectPc    = vecs[i].rpc;
      imemReqReady  = vecs[i].ready;
      imemRespValid = memPend && (memCnt == 1);
      imemRespData  = imemRespValid ? memData(memAddr) : 32'h0;
      #1;
      check32($sformatf("c%0d reqValid", i),  32'(imemReqValid), 32'(vecs[i].eReqV));
      check32($sformatf("c%0d reqAddr", i),   imemReqAddr,       vecs[i].eAddr);
      check32($sformatf("c%0d fetchBusy", i), 32'(fetchBusy),    32'(vecs[i].eBusy));
      check32($sformatf("c%0d ifIdValid", i), 32'(ifIdValid),    32'(vecs[i].eIfV));
      if (vecs[i].eIfV)
        check32($sformatf("c%0d ifIdPc", i), ifIdPc, vecs[i].eIfPc);

      // IF/ID freshly loaded: valid now and the previous edge was not a stall/flush/reset
      if (ifIdValid && !prevHold) begin
        check32($sformatf("c%0d ifid scoreboard nonempty", i), 32'(exp_ifid_q.size() != 0), 32'h1);
        if (exp_ifid_q.size() != 0) begin
          tmp64 = exp_ifid_q.pop_front();
          check32($sformatf("c%0d sb ifIdPc", i),   ifIdPc,   tmp64[63:32]);
          check32($sformatf("c%0d sb ifIdInsn", i), ifIdInsn, tmp64[31:0]);
        end
      end

      accept     = imemReqValid && imemReqReady;
      acceptAddr = imemReqAddr;
      if (accept) begin
        check32($sformatf("c%0d req scoreboard nonempty", i), 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          tmp = exp_q.pop_front();
          check32($sformatf("c%0d sb reqAddr", i), acceptAddr, tmp);
        end
      end

      @(posedge clk);
      prevHold = ctrl.stall || ctrl.flush || rst;
      if (rst) memPend = 1'b0;
      else if (imemRespValid) memPend = 1'b0;
      else if (memPend) memCnt--;
      if (accept && !rst) begin
        memPend = 1'b1;
        memCnt  = vecs[i].delay;
        memAddr = acceptAddr;
      end
      #1;
    end

    check32("req scoreboard drained",  32'(exp_q.size()),      32'h0);
    check32("ifid scoreboard drained", 32'(exp_ifid_q.size()), 32'h0);

    // ---------------- PC wrap sequence ----------------
    wRst = 1'b0;
    wReqReady = 1'b1;
    #1;
    check32("wrap first reqValid", 32'(wReqValid), 32'h1);
    check32("wrap first reqAddr",  wReqAddr,       32'hFFFF_FFFC);
    @(posedge clk); #1;
    wRespValid = 1'b1;
    wRespData  = memData(32'hFFFF_FFFC);
    #1;
    check32("wrap busy", 32'(wBusy), 32'h1);
    @(posedge clk); #1;
    wRespValid = 1'b0;
    #1;
    check32("wrap second reqValid", 32'(wReqValid),  32'h1);
    check32("wrap second reqAddr",  wReqAddr,        32'h0);
    check32("wrap ifIdValid",       32'(wIfIdValid), 32'h1);
    check32("wrap ifIdPc",          wIfIdPc,         32'hFFFF_FFFC);
    check32("wrap ifIdInsn",        wIfIdInsn,       32'h5A5A_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch stage of the in-order pipeline. Holds the PC, issues one instruction-memory request at a time over a valid/ready handshake, and writes the returned instruction into the IF/ID pipeline register. It consumes the `fetchStage` stall/flush controls produced by the stage controller, and the branch/miss redirect from execute. It feeds decode.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `ctrl`  in  StageCtrl  `fetchStage` controls: `.stall` holds PC and IF/ID; `.flush` squashes.
- `redirectValid`  in  1  branch miss or taken branch; load `redirectPc`.
- `redirectPc`  in  32  redirect target; word aligned.
- `imemReqValid`  out  1  request valid.
- `imemReqAddr`  out  32  request address.
- `imemReqReady`  in  1  memory accepts the request this cycle.
- `imemRespValid`  in  1  response valid.
- `imemRespData`  in  32  instruction word.
- `ifIdValid`  out  1  IF/ID holds a live instruction.
- `ifIdPc`  out  32  PC of that instruction.
- `ifIdInsn`  out  32  that instruction.
- `fetchBusy`  out  1  a request is outstanding (state WAIT).

## Operation
- Registers:
  - `pc`: address of the next or outstanding fetch.
  - `state` ∈ {ISSUE, WAIT, HELD}.
  - `discard`: 1 bit.
  - hold buffer: 32-bit instruction.
  - IF/ID: valid, pc, insn.
- `imemReqValid = (state==ISSUE) && !redirectValid && !ctrl.flush`; `imemReqAddr = pc`.
- ISSUE:
  - Request accepted (valid && ready) → WAIT, `discard<=0`.
  - Redirect → `pc<=redirectPc`; stay in ISSUE.
- WAIT: on `redirectValid`, `pc<=redirectPc` and `discard<=1`. On `imemRespValid`:
  - If `discard`, or redirect this cycle: drop the response → ISSUE.
  - Else if `ctrl.flush`: drop the response, `pc` unchanged (refetch) → ISSUE.
  - Else if `ctrl.stall`: store in the hold buffer → HELD.
  - Else: load IF/ID with {1, pc, data}, `pc<=pc+4` → ISSUE.
- HELD:
  - Redirect → drop, `pc<=redirectPc` → ISSUE.
  - Flush → drop, `pc` unchanged → ISSUE.
  - Stall → stay.
  - Otherwise → load IF/ID from the hold buffer, `pc<=pc+4` → ISSUE.
- IF/ID update, in priority order:
  1. rst → valid 0.
  2. `ctrl.flush` → valid 0 (also when stall is set with it).
  3. `ctrl.stall` → hold.
  4. Instruction delivered this cycle → load.
  5. Otherwise → valid 0 (bubble).
- `ifIdPc` and `ifIdInsn` are don't-care while `ifIdValid=0`, but are never X after reset (reset to 0).
- `pc` priority: rst > redirect > `+4` on load > hold. Arithmetic is 32-bit; `+4` wraps modulo 2^32 (`32'hFFFF_FFFC` → `0`).
- The response arrives no earlier than the cycle after acceptance. There is at most one request outstanding.

## Timing
- Reset values:
  - state ISSUE, `pc=RESET_PC`, `discard=0`.
  - `ifIdValid=0`, `ifIdPc=0`, `ifIdInsn=0`.
  - `imemReqValid=1` in the first cycle after reset deasserts.
  - `fetchBusy=0`.
- Latency with a 1-cycle memory:
  - Accept at N, response at N+1.
  - `ifIdValid=1` at N+2.
  - Next request at N+2.
  - Peak throughput is 1 instruction per 2 cycles.
- Redirect takes effect on the next cycle's request: `imemReqAddr=redirectPc` at R+1 if state is ISSUE at R+1.
- An in-flight response after a redirect is always discarded, even if it arrives many cycles later.
- Reset mid-operation aborts everything. The memory shares `rst`, so no stale response follows.

## Structure
- Add the `FetchState` enum (ISSUE, WAIT, HELD) and the `INSN_BYTES=4` constant to `ControllerTypes`, next to `StageCtrl`.
- Reuse the `TRUE`/`FALSE` constants from `BasicTypes`.
- No sub-module. The hold buffer and the FSM are small enough to live in one file.

## Test plan
- **Reset, free run.** Reset, then no stalls, 1-cycle memory returning `addr^32'hA5A5_0000` → requests at 0, 4, 8 every 2 cycles; `ifIdPc` 0, 4, 8 with matching insn; `ifIdValid` alternates 1/0.
- **Stall on response.** `ctrl.stall` held 3 cycles around the response for `pc=8` → state HELD; IF/ID holds the previous instruction; after release `ifIdPc=8`, no new request until then.
- **Redirect while waiting.** `redirectValid`, `redirectPc=32'h100` during WAIT for `pc=C` → response for C dropped, next request addr `0x100`, `ifIdPc=0x100`.
- **Flush with stall.** Flush+stall (delayed branch hazard) in the cycle the response for `pc=10` arrives → `ifIdValid=0`, `pc` stays 0x10, refetch of 0x10.
- **Wrap.** `RESET_PC=32'hFFFF_FFFC` → second request addr `0`.
- **Slow memory.** `imemReqReady` low 4 cycles, then response after 5 cycles → `imemReqValid` steady with stable addr, `fetchBusy=1` only while in WAIT, `ifIdValid=0` throughout the wait.
